// File: rtl/ucsbece154b_icache_pkg.sv
// Shared constants for the instruction cache: FSM state encodings and
// address-field width helpers.
package ucsbece154b_icache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] ICACHE_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ICACHE_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ICACHE_FILL = 2'd2;

    // Tag width left over after byte, word-offset and index fields.
    function automatic int unsigned tag_width(input int unsigned sets, input int unsigned words);
        return ADDR_W - BYTE_OFF_W - $clog2(sets) - $clog2(words);
    endfunction

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// One cache way: per-set valid bit, tag and data block, with a lookup port
// (tag compare + word mux) and independent tag/fill write ports.
module ucsbece154b_icache_way
    import ucsbece154b_icache_pkg::*;
#(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned TAG_W       = tag_width(8, 4),
    localparam int unsigned IDX_W      = $clog2(NUM_SETS),
    localparam int unsigned OFF_W      = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [OFF_W-1:0]  i_word,
    output logic              o_valid,
    output logic              o_hit,
    output logic [WORD_W-1:0] o_word,
    input  logic              i_tag_we,
    input  logic [IDX_W-1:0]  i_tag_index,
    input  logic [TAG_W-1:0]  i_tag_data,
    input  logic              i_fill_we,
    input  logic              i_valid_set,
    input  logic [IDX_W-1:0]  i_fill_index,
    input  logic [OFF_W-1:0]  i_fill_word,
    input  logic [WORD_W-1:0] i_fill_data
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [WORD_W-1:0]   r_data [NUM_SETS][BLOCK_WORDS];

    // A new tag invalidates the line until its last beat lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_tag_index] <= 1'b0;
        end else if (i_valid_set) begin
            r_valid[i_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_tag_index] <= i_tag_data;
        end
        if (i_fill_we) begin
            r_data[i_fill_index][i_fill_word] <= i_fill_data;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_hit   = r_valid[i_index] && (r_tag[i_index] == i_tag);
    assign o_word  = r_data[i_index][i_word];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Set-associative read-only instruction cache: combinational hits, block
// refill FSM on miss, round-robin replacement per set.
module ucsbece154b_icache
    import ucsbece154b_icache_pkg::*;
#(
    parameter int unsigned NUM_SETS    = 8,
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int unsigned OFF_W   = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W   = $clog2(NUM_SETS);
    localparam int unsigned WAY_W   = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W   = tag_width(NUM_SETS, BLOCK_WORDS);
    localparam int unsigned IDX_LSB = BYTE_OFF_W + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [OFF_W-1:0]   r_beat;
    logic [WAY_W-1:0]   r_victim;
    logic               r_victim_rr;
    logic [WAY_W-1:0]   r_rr [NUM_SETS];
    logic [ADDR_W-1:0]  r_mem_addr;

    logic [IDX_W-1:0]    w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [OFF_W-1:0]    w_word;
    logic [IDX_W-1:0]    w_fill_index;
    logic [NUM_WAYS-1:0] w_hit_vec;
    logic [NUM_WAYS-1:0] w_valid_vec;
    logic [WORD_W-1:0]   w_word_arr [NUM_WAYS];
    logic                w_any_hit;
    logic [WORD_W-1:0]   w_hit_word;
    logic [WAY_W-1:0]    w_victim;
    logic                w_victim_rr;
    logic                w_miss;
    logic                w_beat_we;
    logic                w_fill_done;

    assign w_word       = ReadAddress[IDX_LSB-1:BYTE_OFF_W];
    assign w_index      = ReadAddress[TAG_LSB-1:IDX_LSB];
    assign w_tag        = ReadAddress[ADDR_W-1:TAG_LSB];
    assign w_fill_index = r_mem_addr[TAG_LSB-1:IDX_LSB];

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WAYS; gw++) begin : g_way
            ucsbece154b_icache_way #(
                .NUM_SETS    (NUM_SETS),
                .BLOCK_WORDS (BLOCK_WORDS),
                .TAG_W       (TAG_W)
            ) u_way (
                .clk          (clk),
                .reset        (reset),
                .i_index      (w_index),
                .i_tag        (w_tag),
                .i_word       (w_word),
                .o_valid      (w_valid_vec[gw]),
                .o_hit        (w_hit_vec[gw]),
                .o_word       (w_word_arr[gw]),
                .i_tag_we     (w_miss && (w_victim == WAY_W'(gw))),
                .i_tag_index  (w_index),
                .i_tag_data   (w_tag),
                .i_fill_we    (w_beat_we && (r_victim == WAY_W'(gw))),
                .i_valid_set  (w_fill_done && (r_victim == WAY_W'(gw))),
                .i_fill_index (w_fill_index),
                .i_fill_word  (r_beat),
                .i_fill_data  (MemDataIn)
            );
        end
    endgenerate

    // Hit mux and victim choice: lowest invalid way, else the set's pointer.
    always_comb begin
        w_hit_word  = '0;
        w_victim    = r_rr[w_index];
        w_victim_rr = 1'b1;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (w_hit_vec[i]) begin
                w_hit_word = w_hit_word | w_word_arr[i];
            end
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!w_valid_vec[i]) begin
                w_victim    = WAY_W'(i);
                w_victim_rr = 1'b0;
            end
        end
    end

    assign w_any_hit      = |w_hit_vec;
    assign Ready          = (r_state == ICACHE_IDLE) && ReadEnable && w_any_hit;
    assign Instruction    = w_hit_word;
    assign MemReadRequest = (r_state == ICACHE_REQ);
    assign MemReadAddress = r_mem_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ICACHE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_miss       = 1'b0;
        w_beat_we    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            ICACHE_IDLE: begin
                if (ReadEnable && !w_any_hit) begin
                    w_miss       = 1'b1;
                    w_state_next = ICACHE_REQ;
                end
            end
            ICACHE_REQ: begin
                w_state_next = ICACHE_FILL;
            end
            ICACHE_FILL: begin
                if (MemDataReady) begin
                    w_beat_we = 1'b1;
                    if (r_beat == OFF_W'(BLOCK_WORDS - 1)) begin
                        w_fill_done  = 1'b1;
                        w_state_next = ICACHE_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ICACHE_IDLE;
            end
        endcase
    end

    // Refill bookkeeping; the beat counter wraps to zero on the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_addr  <= '0;
            r_beat      <= '0;
            r_victim    <= '0;
            r_victim_rr <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            if (w_miss) begin
                r_mem_addr  <= ReadAddress & ~ADDR_W'(BLOCK_WORDS * 4 - 1);
                r_victim    <= w_victim;
                r_victim_rr <= w_victim_rr;
                r_beat      <= '0;
            end
            if (w_beat_we) begin
                r_beat <= r_beat + OFF_W'(1);
            end
            if (w_fill_done && r_victim_rr) begin
                r_rr[w_fill_index] <= r_rr[w_fill_index] + WAY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Randomized scoreboard bench for ucsbece154b_icache with a set/way reference
// model and a self-contained refill memory.
module tb_ucsbece154b_icache;

    localparam int NS = 8;
    localparam int NW = 4;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ReadEnable = 1'b0;
    logic [31:0] ReadAddress = '0;
    logic [31:0] Instruction;
    logic        Ready;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn = '0;
    logic        MemDataReady = 1'b0;

    ucsbece154b_icache #(.NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW)) dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .MemReadRequest (MemReadRequest),
        .MemReadAddress (MemReadAddress),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int gap   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] refill_q[$];
    logic [31:0] mon_exp;

    // Reference model: which memory blocks each set holds, slot by slot.
    bit          m_v   [NS][NW];
    int unsigned m_tag [NS][NW];
    int unsigned m_ptr [NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h9C + ((a & ~32'h3) >> 2);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
        end
    endfunction

    // Returns 1 on hit; on miss installs the block as the cache should.
    function automatic bit model_access(input logic [31:0] a);
        int unsigned blk = a / (BW * 4);
        int unsigned s   = blk % NS;
        int unsigned t   = blk / NS;
        int victim = -1;
        for (int w = 0; w < NW; w++)
            if (m_v[s][w] && m_tag[s][w] == t) return 1'b1;
        for (int w = 0; w < NW; w++)
            if (!m_v[s][w] && victim < 0) victim = w;
        if (victim < 0) begin
            victim   = int'(m_ptr[s]);
            m_ptr[s] = (m_ptr[s] + 1) % NW;
        end
        m_v[s][victim]   = 1'b1;
        m_tag[s][victim] = t;
        return 1'b0;
    endfunction

    task automatic issue(input logic [31:0] a, output int stall);
        ReadEnable  = 1'b1;
        ReadAddress = a;
        if (model_access(a)) begin
            stall = 0;
        end else begin
            refill_q.push_back(a & ~32'(BW * 4 - 1));
            stall = 2 + BW * (gap + 1);
        end
        exp_q.push_back(mem_word(a));
    endtask

    task automatic fetch(input logic [31:0] a, input bit chk_stall);
        int stall;
        int n = 0;
        bit timed_out = 1'b0;
        issue(a, stall);
        forever begin
            @(negedge clk);
            if (Ready) break;
            n++;
            if (n > 300) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: addr %h never ready after %0d cycles", a, n);
            exp_q.delete();
        end else if (chk_stall) begin
            check("stall_cycles", 32'(n), 32'(stall));
        end
        @(posedge clk);
        #1;
        ReadEnable = 1'b0;
    endtask

    task automatic wait_request(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (MemReadRequest) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL request_timeout: MemReadRequest low, expected a pulse");
        end
    endtask

    // Scoreboard monitor: every Ready cycle consumes one expected word.
    always @(negedge clk) begin
        if (reset && Ready) begin
            if (!ReadEnable) begin
                total++;
                bad++;
                $display("FAIL ready_idle: Ready=1 with ReadEnable=0");
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ready_unexpected: Instruction %h with nothing expected", Instruction);
            end else begin
                mon_exp = exp_q.pop_front();
                check("instruction", Instruction, mon_exp);
            end
        end
    end

    // Refill memory: answers each request with BW beats, 'gap' idle cycles before each.
    initial begin : mem_model
        logic [31:0] base;
        bit abort;
        forever begin
            @(negedge clk);
            if (reset && MemReadRequest) begin
                if (refill_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL refill_unexpected: MemReadAddress %h, expected no refill", MemReadAddress);
                end else begin
                    check("refill_addr", MemReadAddress, refill_q.pop_front());
                end
                base  = MemReadAddress;
                abort = 1'b0;
                @(negedge clk);
                if (!reset) abort = 1'b1;
                else check("request_pulse", 32'(MemReadRequest), 32'd0);
                for (int b = 0; b < BW && !abort; b++) begin
                    for (int g = 0; g < gap && !abort; g++) begin
                        MemDataReady = 1'b0;
                        @(negedge clk);
                        if (!reset) abort = 1'b1;
                    end
                    if (!abort) begin
                        MemDataReady = 1'b1;
                        MemDataIn    = mem_word(base + 32'(4 * b));
                        @(negedge clk);
                        if (!reset) abort = 1'b1;
                    end
                end
                MemDataReady = 1'b0;
                if (!abort) check("refill_addr_hold", MemReadAddress, base);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int st;
        bit seen;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(Ready), 32'd0);
        check("reset_req", 32'(MemReadRequest), 32'd0);
        check("reset_addr", MemReadAddress, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss then same-block hits.
        gap = 0;
        fetch(32'h10, 1'b1);
        fetch(32'h14, 1'b1);
        fetch(32'h18, 1'b1);
        fetch(32'h1C, 1'b1);

        // Five blocks into set 1, then round-robin eviction order.
        fetch(32'h090, 1'b1);
        fetch(32'h110, 1'b1);
        fetch(32'h190, 1'b1);
        fetch(32'h210, 1'b1);
        fetch(32'h010, 1'b1);
        fetch(32'h194, 1'b1);
        fetch(32'h214, 1'b1);
        fetch(32'h098, 1'b1);

        // Beats every third cycle.
        gap = 2;
        fetch(32'h408, 1'b1);
        fetch(32'h400, 1'b1);
        fetch(32'h404, 1'b1);
        fetch(32'h40C, 1'b1);

        // Redirect during FILL: original block completes, new address misses.
        gap = 0;
        issue(32'h040, st);
        wait_request(seen);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        fetch(32'h200, 1'b0);
        fetch(32'h044, 1'b1);

        // Reset after two beats: the line must not survive.
        issue(32'h300, st);
        wait_request(seen);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midfill_reset_ready", 32'(Ready), 32'd0);
        check("midfill_reset_req", 32'(MemReadRequest), 32'd0);
        check("midfill_reset_addr", MemReadAddress, 32'd0);
        exp_q.delete();
        refill_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        fetch(32'h300, 1'b1);

        // Random traffic over a small footprint to mix hits and evictions.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            gap = int'($urandom_range(0, 2));
            a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            fetch(a, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0 || refill_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: %0d instructions and %0d refills still expected",
                     exp_q.size(), refill_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
